control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multicycle main control FSM for the MIPS-subset datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the register-bank strobes (REG_RD, REG_WR, active-low), the immediate-extension select SEL_I, the ALU, memory and PC controls. Handshakes with instruction/data memory via req/ack.

## Interface
- No parameters; all encodings are fixed constants.
- reloj  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- OPCODE  in  6  IR[31:26]; valid from DECODE onward
- FUNCT  in  6  IR[5:0]
- ZERO  in  1  ALU zero flag; valid in BRANCH
- MEM_ACK  in  1  memory completed current access this cycle
- MEM_REQ  out  1  memory access request; held until MEM_ACK
- MEM_WE  out  1  1 = write access (only with MEM_REQ)
- IORD  out  1  0 = address from PC, 1 = from ALU result register
- IR_WR, PC_WR  out  1 each  load IR / load PC
- PC_SRC  out  2  00 PC+4, 01 branch target, 10 jump address out_addr
- REG_RD  out  1  active-low; 0 = bank drives DOA/DOB
- REG_WR  out  1  active-low; 0 = write DI to DIR_WRA at next edge
- REG_DST  out  1  1 = rd, 0 = rt
- MEM_TO_REG  out  1  1 = write-back from memory data register
- SEL_I  out  1  1 = sign extend, 0 = zero extend
- ALU_SRC_A  out  1  0 = PC, 1 = DOA
- ALU_SRC_B  out  2  00 DOB, 01 const 4, 10 extended imm, 11 imm<<2
- ALU_OP  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- ILEGAL  out  1  sticky illegal-instruction flag
- INSTR_CNT  out  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_LD, MEM_ST, WB_R, WB_I, WB_MEM, BRANCH, JUMP.
- Outputs are Moore, decoded from the state register and the latched OPCODE/FUNCT.
  - Defaults: every strobe inactive, i.e. REG_RD=1, REG_WR=1, others 0.
- IDLE: entered on reset; lasts one cycle; then goes to FETCH.
- FETCH:
  - Outputs: MEM_REQ=1, IORD=0, ALU_SRC_A=0, ALU_SRC_B=01, ALU_OP=ADD.
  - Holds while MEM_ACK=0.
  - In the MEM_ACK=1 cycle: IR_WR=1 and PC_WR=1 (PC_SRC=00), next state DECODE.
- DECODE:
  - Outputs: REG_RD=0. Branch target is precomputed (ALU_SRC_A=0, ALU_SRC_B=11, ADD, SEL_I=1).
  - Dispatch by OPCODE:
    - 0x00 → EXEC_R
    - 0x08, 0x0C, 0x0D → EXEC_I
    - 0x23, 0x2B → MEM_ADDR
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - any other value → set ILEGAL, go to FETCH
  - R-type with FUNCT outside {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt} is also illegal.
- EXEC_R: REG_RD=0, ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP from FUNCT; then WB_R.
- EXEC_I:
  - REG_RD=0, ALU_SRC_A=1, ALU_SRC_B=10.
  - addi: SEL_I=1, ADD. andi: SEL_I=0, AND. ori: SEL_I=0, OR.
  - Next state WB_I.
- MEM_ADDR: REG_RD=0, SEL_I=1, ALU_SRC_A=1, ALU_SRC_B=10, ADD; lw → MEM_LD, sw → MEM_ST.
- MEM_LD / MEM_ST:
  - MEM_REQ=1, IORD=1; MEM_WE=1 in MEM_ST.
  - Holds until MEM_ACK. Then MEM_LD → WB_MEM, MEM_ST → FETCH.
- WB_R: REG_WR=0, REG_DST=1, MEM_TO_REG=0.
- WB_I: REG_WR=0, REG_DST=0, MEM_TO_REG=0.
- WB_MEM: REG_WR=0, REG_DST=0, MEM_TO_REG=1.
- All WB states go to FETCH.
- BRANCH: REG_RD=0, ALU_SRC_A=1, ALU_SRC_B=00, SUB, PC_SRC=01, PC_WR=ZERO; then FETCH.
- JUMP: PC_SRC=10, PC_WR=1; then FETCH.
- INSTR_CNT increments by 1, wrapping at 2^32, on the edge leaving:
  - any WB state;
  - MEM_ST with ack;
  - BRANCH;
  - JUMP.
  - Illegal instructions are not counted.

## Timing
- Reset is sampled at the edge. Afterwards: state=IDLE, ILEGAL=0, INSTR_CNT=0, all strobes inactive (REG_RD=REG_WR=1). MEM_REQ drops within the same edge even mid-access.
- CPI with zero-wait memory (FETCH acked first cycle): R/addi/andi/ori 4, lw 5, sw 4, beq 3, j 3. Each wait cycle adds 1.
- REG_WR is low for exactly one cycle per write-back instruction. REG_RD is never low in FETCH, IDLE or WB states.
- MEM_REQ, MEM_WE and IORD stay stable from the first request cycle through the ack cycle inclusive. MEM_ACK outside a request state is ignored.
- ILEGAL clears only on reset.

## Structure
- Shared package `ctrl_pkg`: opcode and funct constants, state enum, ALU_OP codes, PC_SRC and ALU_SRC_B codes.
- Sub-module `control_alu`: combinational; maps (class: add/sub/funct/and/or, FUNCT) → ALU_OP plus an illegal-funct flag.

## Test plan
- add (op 0, funct 0x20), ack on the first FETCH cycle → REG_WR=0 exactly in cycle 4, REG_DST=1, ALU_OP=0010, INSTR_CNT 0→1.
- ori (0x0D) then addi (0x08) → SEL_I=0 then SEL_I=1 in the respective EXEC_I cycles; ALU_OP 0001 then 0010.
- lw with MEM_ACK delayed 3 cycles in MEM_LD → MEM_REQ=1, IORD=1 held 4 cycles, WB_MEM follows, total 8 cycles.
- beq with ZERO=1 and ZERO=0 → PC_WR=1 / PC_WR=0 in BRANCH with PC_SRC=01; j → PC_SRC=10, PC_WR=1.
- Opcode 0x3F, and op 0 with funct 0x3F → ILEGAL=1, return to FETCH, INSTR_CNT unchanged, no REG_WR pulse.
- reset asserted in MEM_ST mid-wait → next cycle IDLE, MEM_REQ=0, MEM_WE=0, INSTR_CNT=0, ILEGAL=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control: opcodes, functs, ALU/PC/mux codes,
// FSM state constants and the ALU operation class handed to control_alu.
package ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  localparam logic [1:0] PcSrcInc    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  typedef enum logic [2:0] {
    AluClsAdd, AluClsSub, AluClsFunct, AluClsAnd, AluClsOr
  } alu_cls_e;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StFetch   = 4'd1;
  localparam logic [3:0] StDecode  = 4'd2;
  localparam logic [3:0] StExecR   = 4'd3;
  localparam logic [3:0] StExecI   = 4'd4;
  localparam logic [3:0] StMemAddr = 4'd5;
  localparam logic [3:0] StMemLd   = 4'd6;
  localparam logic [3:0] StMemSt   = 4'd7;
  localparam logic [3:0] StWbR     = 4'd8;
  localparam logic [3:0] StWbI     = 4'd9;
  localparam logic [3:0] StWbMem   = 4'd10;
  localparam logic [3:0] StBranch  = 4'd11;
  localparam logic [3:0] StJump    = 4'd12;

endpackage

// File: rtl/control_multiciclo_if.sv
// Memory request/acknowledge handshake between the control FSM and instruction/data memory.
interface control_multiciclo_if;
  logic MEM_REQ;
  logic MEM_WE;
  logic IORD;
  logic MEM_ACK;

  modport master (output MEM_REQ, output MEM_WE, output IORD, input MEM_ACK);
  modport slave  (input MEM_REQ, input MEM_WE, input IORD, output MEM_ACK);
endinterface

// File: rtl/control_alu.sv
// Combinational ALU-operation decoder: operation class plus FUNCT to ALU_OP, and a flag telling
// whether FUNCT is one of the supported R-type codes.
module control_alu
  import ctrl_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       funct_ilegal_o
);

  logic [3:0] funct_op;

  always_comb begin
    funct_op       = AluAdd;
    funct_ilegal_o = 1'b0;
    case (funct_i)
      FnAdd:   funct_op = AluAdd;
      FnSub:   funct_op = AluSub;
      FnAnd:   funct_op = AluAnd;
      FnOr:    funct_op = AluOr;
      FnSlt:   funct_op = AluSlt;
      default: funct_ilegal_o = 1'b1;
    endcase
  end

  always_comb begin
    alu_op_o = AluAdd;
    case (cls_i)
      AluClsAdd:   alu_op_o = AluAdd;
      AluClsSub:   alu_op_o = AluSub;
      AluClsFunct: alu_op_o = funct_op;
      AluClsAnd:   alu_op_o = AluAnd;
      AluClsOr:    alu_op_o = AluOr;
      default:     alu_op_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back, drives datapath
// strobes (register bank strobes active-low), tracks illegal instructions and retired count.
module control_multiciclo
  import ctrl_pkg::*;
(
  input  logic                        reloj,
  input  logic                        reset,
  control_multiciclo_if.master        mem,
  input  logic [5:0]                  OPCODE,
  input  logic [5:0]                  FUNCT,
  input  logic                        ZERO,
  output logic                        IR_WR,
  output logic                        PC_WR,
  output logic [1:0]                  PC_SRC,
  output logic                        REG_RD,
  output logic                        REG_WR,
  output logic                        REG_DST,
  output logic                        MEM_TO_REG,
  output logic                        SEL_I,
  output logic                        ALU_SRC_A,
  output logic [1:0]                  ALU_SRC_B,
  output logic [3:0]                  ALU_OP,
  output logic                        ILEGAL,
  output logic [31:0]                 INSTR_CNT
);

  logic [3:0]  state_q, state_d;
  logic        ilegal_q, ilegal_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mem_req, mem_we, iord;
  logic        alu_en;
  alu_cls_e    alu_cls;
  logic [3:0]  alu_op_raw;
  logic        funct_ilegal;

  // Kept apart from the main decode so the ALU sub-module sits outside that block's fan-in.
  always_comb begin
    alu_cls = AluClsAdd;
    alu_en  = 1'b0;
    case (state_q)
      StFetch, StDecode, StMemAddr: alu_en = 1'b1;
      StExecR: begin alu_en = 1'b1; alu_cls = AluClsFunct; end
      StBranch: begin alu_en = 1'b1; alu_cls = AluClsSub; end
      StExecI: begin
        alu_en = 1'b1;
        if (OPCODE == OpAndi)     alu_cls = AluClsAnd;
        else if (OPCODE == OpOri) alu_cls = AluClsOr;
      end
      default: ;
    endcase
  end

  control_alu u_alu (
    .cls_i          (alu_cls),
    .funct_i        (FUNCT),
    .alu_op_o       (alu_op_raw),
    .funct_ilegal_o (funct_ilegal)
  );

  assign ALU_OP = alu_en ? alu_op_raw : 4'b0000;

  always_comb begin
    state_d    = state_q;
    ilegal_d   = ilegal_q;
    cnt_d      = cnt_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    IR_WR      = 1'b0;
    PC_WR      = 1'b0;
    PC_SRC     = PcSrcInc;
    REG_RD     = 1'b1;
    REG_WR     = 1'b1;
    REG_DST    = 1'b0;
    MEM_TO_REG = 1'b0;
    SEL_I      = 1'b0;
    ALU_SRC_A  = 1'b0;
    ALU_SRC_B  = SrcBReg;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req   = 1'b1;
        ALU_SRC_B = SrcBFour;
        if (mem.MEM_ACK) begin
          IR_WR   = 1'b1;
          PC_WR   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        REG_RD    = 1'b0;
        ALU_SRC_B = SrcBImmSh;
        SEL_I     = 1'b1;
        case (OPCODE)
          OpRtype: begin
            if (funct_ilegal) begin
              ilegal_d = 1'b1;
              state_d  = StFetch;
            end else begin
              state_d = StExecR;
            end
          end
          OpAddi, OpAndi, OpOri: state_d = StExecI;
          OpLw, OpSw:            state_d = StMemAddr;
          OpBeq:                 state_d = StBranch;
          OpJ:                   state_d = StJump;
          default: begin
            ilegal_d = 1'b1;
            state_d  = StFetch;
          end
        endcase
      end
      StExecR: begin
        REG_RD    = 1'b0;
        ALU_SRC_A = 1'b1;
        state_d   = StWbR;
      end
      StExecI: begin
        REG_RD    = 1'b0;
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = SrcBImm;
        SEL_I     = (OPCODE == OpAddi);
        state_d   = StWbI;
      end
      StMemAddr: begin
        REG_RD    = 1'b0;
        SEL_I     = 1'b1;
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = SrcBImm;
        state_d   = (OPCODE == OpSw) ? StMemSt : StMemLd;
      end
      StMemLd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem.MEM_ACK) state_d = StWbMem;
      end
      StMemSt: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem.MEM_ACK) begin
          state_d = StFetch;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      StWbR, StWbI, StWbMem: begin
        REG_WR     = 1'b0;
        REG_DST    = (state_q == StWbR);
        MEM_TO_REG = (state_q == StWbMem);
        state_d    = StFetch;
        cnt_d      = cnt_q + 32'd1;
      end
      StBranch: begin
        REG_RD    = 1'b0;
        ALU_SRC_A = 1'b1;
        PC_SRC    = PcSrcBranch;
        PC_WR     = ZERO;
        state_d   = StFetch;
        cnt_d     = cnt_q + 32'd1;
      end
      StJump: begin
        PC_SRC  = PcSrcJump;
        PC_WR   = 1'b1;
        state_d = StFetch;
        cnt_d   = cnt_q + 32'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q  <= StIdle;
      ilegal_q <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      ilegal_q <= ilegal_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem.MEM_REQ = mem_req;
  assign mem.MEM_WE  = mem_we;
  assign mem.IORD    = iord;
  assign ILEGAL      = ilegal_q;
  assign INSTR_CNT   = cnt_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: each instruction is expanded into its expected per-cycle output
// schedule from the instruction-class rules, then replayed against the DUT cycle by cycle.
module tb_control_multiciclo;

  typedef struct packed {
    logic        mem_req, mem_we, iord, ir_wr, pc_wr;
    logic [1:0]  pc_src;
    logic        reg_rd, reg_wr, reg_dst, mem_to_reg, sel_i, src_a;
    logic [1:0]  src_b;
    logic [3:0]  alu_op;
    logic        ilegal;
    logic [31:0] cnt;
  } outv_t;

  typedef struct packed {
    logic       rst, ack, zero;
    logic [5:0] op, fn;
    outv_t      exp;
  } rec_t;

  logic reloj = 1'b0;
  logic reset = 1'b1;
  always #5 reloj = ~reloj;

  control_multiciclo_if mif ();
  logic [5:0]  OPCODE, FUNCT;
  logic        ZERO;
  logic        IR_WR, PC_WR, REG_RD, REG_WR, REG_DST, MEM_TO_REG, SEL_I, ALU_SRC_A, ILEGAL;
  logic [1:0]  PC_SRC, ALU_SRC_B;
  logic [3:0]  ALU_OP;
  logic [31:0] INSTR_CNT;
  outv_t       dut_v;

  control_multiciclo dut (
    .reloj      (reloj),
    .reset      (reset),
    .mem        (mif),
    .OPCODE     (OPCODE),
    .FUNCT      (FUNCT),
    .ZERO       (ZERO),
    .IR_WR      (IR_WR),
    .PC_WR      (PC_WR),
    .PC_SRC     (PC_SRC),
    .REG_RD     (REG_RD),
    .REG_WR     (REG_WR),
    .REG_DST    (REG_DST),
    .MEM_TO_REG (MEM_TO_REG),
    .SEL_I      (SEL_I),
    .ALU_SRC_A  (ALU_SRC_A),
    .ALU_SRC_B  (ALU_SRC_B),
    .ALU_OP     (ALU_OP),
    .ILEGAL     (ILEGAL),
    .INSTR_CNT  (INSTR_CNT)
  );

  assign dut_v = {mif.MEM_REQ, mif.MEM_WE, mif.IORD, IR_WR, PC_WR, PC_SRC, REG_RD, REG_WR,
                  REG_DST, MEM_TO_REG, SEL_I, ALU_SRC_A, ALU_SRC_B, ALU_OP, ILEGAL, INSTR_CNT};

  rec_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_cnt  = 32'd0;
  logic        m_ileg = 1'b0;
  logic [5:0]  cur_op, cur_fn;
  logic [5:0]  fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [3:0]  ops[5] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7};
  logic [5:0]  legal_ops[8] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};

  function automatic outv_t base();
    outv_t v = '0;
    v.reg_rd = 1'b1;
    v.reg_wr = 1'b1;
    v.ilegal = m_ileg;
    v.cnt    = m_cnt;
    return v;
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    for (int i = 0; i < 5; i++) if (fns[i] == fn) return ops[i];
    return 4'hx;
  endfunction

  function automatic bit is_fn(input logic [5:0] fn);
    for (int i = 0; i < 5; i++) if (fns[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_op(input logic [5:0] op);
    for (int i = 0; i < 8; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input outv_t e, input logic ack, input logic zero, input logic rst);
    rec_t r;
    r.rst = rst; r.ack = ack; r.zero = zero; r.op = cur_op; r.fn = cur_fn; r.exp = e;
    q.push_back(r);
  endtask

  task automatic pin(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, req);
    end
  endtask

  task automatic gen_fetch(input int fw);
    outv_t v;
    for (int i = 0; i <= fw; i++) begin
      v = base(); v.mem_req = 1; v.src_b = 2'b01; v.alu_op = 4'h2;
      if (i == fw) begin v.ir_wr = 1; v.pc_wr = 1; end
      push(v, (i == fw), 1'($urandom % 2), 0);
    end
    v = base(); v.reg_rd = 0; v.src_b = 2'b11; v.alu_op = 4'h2; v.sel_i = 1;
    push(v, 1'($urandom % 2), 1'($urandom % 2), 0);
  endtask

  task automatic gen_addr();
    outv_t v = base();
    v.reg_rd = 0; v.sel_i = 1; v.src_a = 1; v.src_b = 2'b10; v.alu_op = 4'h2;
    push(v, 1'($urandom % 2), 0, 0);
  endtask

  // kinds: 0 R, 1 addi, 2 andi, 3 ori, 4 lw, 5 sw, 6 beq, 7 j, 8 bad op, 9 bad funct,
  // 10 opcode 0x3F, 11 R-type funct 0x3F
  task automatic gen(input int kind, input int fw, input int mw, input logic z, output int n);
    int    start = q.size();
    outv_t v;
    cur_fn = 6'($urandom);
    case (kind)
      0: begin cur_op = 6'h00; cur_fn = fns[$urandom_range(0, 4)]; end
      1: cur_op = 6'h08;
      2: cur_op = 6'h0C;
      3: cur_op = 6'h0D;
      4: cur_op = 6'h23;
      5: cur_op = 6'h2B;
      6: cur_op = 6'h04;
      7: cur_op = 6'h02;
      8: do cur_op = 6'($urandom); while (is_op(cur_op));
      9: begin cur_op = 6'h00; do cur_fn = 6'($urandom); while (is_fn(cur_fn)); end
      10: cur_op = 6'h3F;
      default: begin cur_op = 6'h00; cur_fn = 6'h3F; end
    endcase
    gen_fetch(fw);
    case (kind)
      0, 1, 2, 3: begin
        v = base(); v.reg_rd = 0; v.src_a = 1;
        if (kind == 0) v.alu_op = r_alu(cur_fn);
        else begin
          v.src_b  = 2'b10;
          v.sel_i  = (kind == 1);
          v.alu_op = (kind == 1) ? 4'h2 : (kind == 2) ? 4'h0 : 4'h1;
        end
        push(v, 1'($urandom % 2), 1'($urandom % 2), 0);
        v = base(); v.reg_wr = 0; v.reg_dst = (kind == 0);
        push(v, 1'($urandom % 2), 1'($urandom % 2), 0);
        m_cnt++;
      end
      4, 5: begin
        gen_addr();
        for (int i = 0; i <= mw; i++) begin
          v = base(); v.mem_req = 1; v.iord = 1; v.mem_we = (kind == 5);
          push(v, (i == mw), 1'($urandom % 2), 0);
        end
        if (kind == 4) begin
          v = base(); v.reg_wr = 0; v.mem_to_reg = 1;
          push(v, 1'($urandom % 2), 1'($urandom % 2), 0);
        end
        m_cnt++;
      end
      6: begin
        v = base(); v.reg_rd = 0; v.src_a = 1; v.alu_op = 4'h6; v.pc_src = 2'b01; v.pc_wr = z;
        push(v, 1'($urandom % 2), z, 0);
        m_cnt++;
      end
      7: begin
        v = base(); v.pc_src = 2'b10; v.pc_wr = 1;
        push(v, 1'($urandom % 2), 1'($urandom % 2), 0);
        m_cnt++;
      end
      default: m_ileg = 1'b1;
    endcase
    n = q.size() - start;
  endtask

  // sw whose data access is cut short by reset after k unacknowledged cycles.
  task automatic gen_sw_reset(input int fw, input int k);
    outv_t v;
    cur_op = 6'h2B;
    gen_fetch(fw);
    gen_addr();
    for (int i = 0; i < k; i++) begin
      v = base(); v.mem_req = 1; v.iord = 1; v.mem_we = 1;
      push(v, 0, 0, (i == k - 1));
    end
    m_cnt = 0; m_ileg = 0;
    push(base(), 1'($urandom % 2), 0, 0);
  endtask

  initial begin
    int n;
    int iord_cnt;
    logic [31:0] cnt_before;
    mif.MEM_ACK = 1'b0;
    OPCODE = 6'h00; FUNCT = 6'h00; ZERO = 1'b0;
    cur_op = 6'h00; cur_fn = 6'h00;

    push(base(), 1'b1, 0, 0);  // IDLE right after reset
    cur_fn = 6'h20;
    gen_fetch(0);
    q.pop_back(); q.pop_back();  // drop helper output; the directed add below is rebuilt
    gen(0, 0, 0, 0, n);
    pin("add_cpi", n, 4);
    pin("add_wb_regwr", int'(q[q.size()-1].exp.reg_wr), 0);
    pin("add_wb_regdst", int'(q[q.size()-1].exp.reg_dst), 1);
    gen(3, 0, 0, 0, n);
    pin("ori_sel_i", int'(q[q.size()-2].exp.sel_i), 0);
    pin("ori_alu", int'(q[q.size()-2].exp.alu_op), 1);
    gen(1, 0, 0, 0, n);
    pin("addi_sel_i", int'(q[q.size()-2].exp.sel_i), 1);
    pin("addi_alu", int'(q[q.size()-2].exp.alu_op), 2);
    gen(4, 0, 3, 0, n);
    pin("lw_cycles", n, 8);
    iord_cnt = 0;
    for (int i = q.size() - n; i < q.size(); i++) iord_cnt += int'(q[i].exp.iord);
    pin("lw_iord_cycles", iord_cnt, 4);
    gen(6, 0, 0, 1, n);
    pin("beq_taken_pcwr", int'(q[q.size()-1].exp.pc_wr), 1);
    pin("beq_taken_cpi", n, 3);
    gen(6, 0, 0, 0, n);
    pin("beq_not_taken_pcwr", int'(q[q.size()-1].exp.pc_wr), 0);
    gen(7, 0, 0, 0, n);
    pin("j_pc_src", int'(q[q.size()-1].exp.pc_src), 2);
    cnt_before = m_cnt;
    gen(10, 0, 0, 0, n);
    gen(11, 1, 0, 0, n);
    pin("illegal_cnt_held", int'(m_cnt), int'(cnt_before));
    pin("illegal_flag", int'(m_ileg), 1);
    pin("cnt_after_directed", int'(m_cnt), 7);

    for (int i = 0; i < 60; i++)
      gen($urandom_range(0, 9), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom % 2), n);
    if (!m_ileg) gen(8, 0, 0, 0, n);
    gen_sw_reset(1, 3);
    for (int i = 0; i < 15; i++)
      gen($urandom_range(0, 9), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom % 2), n);

    repeat (2) @(posedge reloj);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge reloj);
      #1;
      reset       = q[i].rst;
      mif.MEM_ACK = q[i].ack;
      ZERO        = q[i].zero;
      OPCODE      = q[i].op;
      FUNCT       = q[i].fn;
      @(negedge reloj);
      checks++;
      if (dut_v !== q[i].exp) begin
        errors++;
        $display("FAIL cyc %0d op %h fn %h got %h want %h", i, q[i].op, q[i].fn, dut_v, q[i].exp);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
